// File: rtl/control_pkg.sv
// Shared types and constants for the LC-3b multicycle control FSM:
// opcodes, ALU operations, state codes and datapath mux-select encodings.
package control_pkg;

   typedef enum logic [3:0] {
      op_br   = 4'b0000,
      op_add  = 4'b0001,
      op_ldb  = 4'b0010,
      op_stb  = 4'b0011,
      op_jsr  = 4'b0100,
      op_and  = 4'b0101,
      op_ldr  = 4'b0110,
      op_str  = 4'b0111,
      op_rti  = 4'b1000,
      op_not  = 4'b1001,
      op_ldi  = 4'b1010,
      op_sti  = 4'b1011,
      op_jmp  = 4'b1100,
      op_shf  = 4'b1101,
      op_lea  = 4'b1110,
      op_trap = 4'b1111
   } lc3b_opcode;

   typedef enum logic [2:0] {
      alu_add  = 3'd0,
      alu_and  = 3'd1,
      alu_not  = 3'd2,
      alu_pass = 3'd3,
      alu_sll  = 3'd4,
      alu_srl  = 3'd5,
      alu_sra  = 3'd6
   } lc3b_aluop;

   // Controller states; plain constants so older code can keep comparing raw codes.
   localparam logic [4:0] S_FETCH1    = 5'd0;
   localparam logic [4:0] S_FETCH2    = 5'd1;
   localparam logic [4:0] S_FETCH3    = 5'd2;
   localparam logic [4:0] S_DECODE    = 5'd3;
   localparam logic [4:0] S_ALU       = 5'd4;
   localparam logic [4:0] S_SHF       = 5'd5;
   localparam logic [4:0] S_LEA       = 5'd6;
   localparam logic [4:0] S_BR_TAKEN  = 5'd7;
   localparam logic [4:0] S_JMP       = 5'd8;
   localparam logic [4:0] S_STORE_R7  = 5'd9;
   localparam logic [4:0] S_JSR_PC    = 5'd10;
   localparam logic [4:0] S_CALC_ADDR = 5'd11;
   localparam logic [4:0] S_LD_RD     = 5'd12;
   localparam logic [4:0] S_LD_WB     = 5'd13;
   localparam logic [4:0] S_ST_MDR    = 5'd14;
   localparam logic [4:0] S_ST_WR     = 5'd15;
   localparam logic [4:0] S_TRAP_MAR  = 5'd16;
   localparam logic [4:0] S_TRAP_RD   = 5'd17;
   localparam logic [4:0] S_TRAP_PC   = 5'd18;

   localparam logic [1:0] PCMUX_PC2      = 2'd0;
   localparam logic [1:0] PCMUX_BRADD    = 2'd1;
   localparam logic [1:0] PCMUX_SR1      = 2'd2;
   localparam logic [1:0] PCMUX_MDR      = 2'd3;

   localparam logic [1:0] MARMUX_ALU     = 2'd0;
   localparam logic [1:0] MARMUX_PC      = 2'd1;
   localparam logic [1:0] MARMUX_MDR     = 2'd2;
   localparam logic [1:0] MARMUX_TRAPVEC = 2'd3;

   localparam logic       MDRMUX_ALU     = 1'b0;
   localparam logic       MDRMUX_MEM     = 1'b1;

   localparam logic [2:0] RFMUX_ALU      = 3'd0;
   localparam logic [2:0] RFMUX_MDR      = 3'd1;
   localparam logic [2:0] RFMUX_BRADD    = 3'd2;
   localparam logic [2:0] RFMUX_PC       = 3'd3;
   localparam logic [2:0] RFMUX_ZEXTLO   = 3'd4;
   localparam logic [2:0] RFMUX_ZEXTHI   = 3'd5;

   localparam logic [2:0] ALUMUX_SR2     = 3'd0;
   localparam logic [2:0] ALUMUX_SEXT5   = 3'd1;
   localparam logic [2:0] ALUMUX_ADJ6    = 3'd2;
   localparam logic [2:0] ALUMUX_ZEXT4   = 3'd3;
   localparam logic [2:0] ALUMUX_SEXT6   = 3'd4;

   // States that hold a memory request open until mem_resp arrives.
   function automatic logic is_wait_state(input logic [4:0] s);
      return (s == S_FETCH2) || (s == S_LD_RD) || (s == S_ST_WR) || (s == S_TRAP_RD);
   endfunction

endpackage

// File: rtl/control_if.sv
// Unified-memory handshake between the control FSM (master) and memory (slave).
interface control_if;
   logic       mem_read;
   logic       mem_write;
   logic [1:0] mem_byte_enable;
   logic       mem_resp;
   logic       mem_address0;

   modport master (
      output mem_read, mem_write, mem_byte_enable,
      input  mem_resp, mem_address0
   );

   modport slave (
      input  mem_read, mem_write, mem_byte_enable,
      output mem_resp, mem_address0
   );
endinterface

// File: rtl/control_mem_wait.sv
// Memory wait-state watchdog: counts cycles spent in a wait state without a
// response and emits a one-cycle timeout pulse at MEM_TIMEOUT (0 disables it).
module ctrl_mem_wait #(
   parameter int MEM_TIMEOUT = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic waiting,
   input  logic mem_resp,
   output logic timeout
);

   localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

   logic [CW-1:0] count;

   assign timeout = (MEM_TIMEOUT != 0) && waiting && !mem_resp && (count == LAST);

   // Counter restarts whenever we are outside a wait state, the access completes or it times out.
   always_ff @(posedge clk) begin
      if (rst || !waiting || mem_resp || timeout)
         count <= '0;
      else
         count <= count + 1'b1;
   end

endmodule

// File: rtl/control.sv
// LC-3b multicycle control FSM. Moore outputs decode from the current state
// (plus IR bits / byte lane). Optional performance counters are built when
// CONTROL_PERF_CNT_EN is defined.
module control
   import control_pkg::*;
#(
   parameter int MEM_TIMEOUT = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] opcode,
   input  logic       instruction4,
   input  logic       instruction5,
   input  logic       instruction11,
   input  logic       branch_enable,
   control_if.master  mem_bus,
   output logic [1:0] pcmux_sel,
   output logic [1:0] marmux_sel,
   output logic [2:0] alumux_sel,
   output logic [2:0] regfilemux_sel,
   output logic       storemux_sel,
   output logic       mdrmux_sel,
   output logic       destmux_sel,
   output logic       offsetmux_sel,
   output logic       load_pc,
   output logic       load_cc,
   output logic       load_ir,
   output logic       load_mar,
   output logic       load_mdr,
   output logic       load_regfile,
   output logic [2:0] aluop,
   output logic       mem_error
`ifdef CONTROL_PERF_CNT_EN
   ,
   output logic [31:0] instr_count,
   output logic [31:0] cycle_count
`endif
);

   logic [4:0] state, next_state;
   logic       timeout;
   logic       error_q;
   logic       rd_req, wr_req;
   logic [1:0] byte_en;

   ctrl_mem_wait #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
      .clk      (clk),
      .rst      (rst),
      .waiting  (is_wait_state(state)),
      .mem_resp (mem_bus.mem_resp),
      .timeout  (timeout)
   );

   // State register; reset always returns to the start of instruction fetch.
   always_ff @(posedge clk) begin
      if (rst)
         state <= S_FETCH1;
      else
         state <= next_state;
   end

   // Next-state logic: wait states leave on mem_resp, or bail to fetch on timeout.
   always_comb begin
      next_state = S_FETCH1;
      case (state)
         S_FETCH1: next_state = S_FETCH2;
         S_FETCH2: next_state = timeout ? S_FETCH1 : (mem_bus.mem_resp ? S_FETCH3 : S_FETCH2);
         S_FETCH3: next_state = S_DECODE;
         S_DECODE: begin
            case (opcode)
               op_add, op_and, op_not:         next_state = S_ALU;
               op_shf:                         next_state = S_SHF;
               op_lea:                         next_state = S_LEA;
               op_br:                          next_state = branch_enable ? S_BR_TAKEN : S_FETCH1;
               op_jmp:                         next_state = S_JMP;
               op_jsr, op_trap:                next_state = S_STORE_R7;
               op_ldr, op_ldb, op_str, op_stb: next_state = S_CALC_ADDR;
               default:                        next_state = S_FETCH1;
            endcase
         end
         S_STORE_R7:  next_state = (opcode == op_trap) ? S_TRAP_MAR : S_JSR_PC;
         S_CALC_ADDR: next_state = (opcode == op_ldr || opcode == op_ldb) ? S_LD_RD : S_ST_MDR;
         S_LD_RD:     next_state = timeout ? S_FETCH1 : (mem_bus.mem_resp ? S_LD_WB : S_LD_RD);
         S_ST_MDR:    next_state = S_ST_WR;
         S_ST_WR:     next_state = (timeout || mem_bus.mem_resp) ? S_FETCH1 : S_ST_WR;
         S_TRAP_MAR:  next_state = S_TRAP_RD;
         S_TRAP_RD:   next_state = timeout ? S_FETCH1 : (mem_bus.mem_resp ? S_TRAP_PC : S_TRAP_RD);
         default:     next_state = S_FETCH1;
      endcase
   end

   // Moore output decode; everything is forced idle while reset is asserted.
   always_comb begin
      pcmux_sel      = PCMUX_PC2;
      marmux_sel     = MARMUX_ALU;
      alumux_sel     = ALUMUX_SR2;
      regfilemux_sel = RFMUX_ALU;
      storemux_sel   = 1'b0;
      mdrmux_sel     = MDRMUX_ALU;
      destmux_sel    = 1'b0;
      offsetmux_sel  = 1'b0;
      load_pc        = 1'b0;
      load_cc        = 1'b0;
      load_ir        = 1'b0;
      load_mar       = 1'b0;
      load_mdr       = 1'b0;
      load_regfile   = 1'b0;
      aluop          = alu_add;
      rd_req         = 1'b0;
      wr_req         = 1'b0;
      byte_en        = 2'b11;
      if (!rst) begin
         case (state)
            S_FETCH1: begin
               marmux_sel = MARMUX_PC;
               load_mar   = 1'b1;
               pcmux_sel  = PCMUX_PC2;
               load_pc    = 1'b1;
            end
            S_FETCH2, S_LD_RD, S_TRAP_RD: begin
               rd_req     = 1'b1;
               mdrmux_sel = MDRMUX_MEM;
               load_mdr   = 1'b1;
            end
            S_FETCH3: load_ir = 1'b1;
            S_ALU: begin
               alumux_sel   = instruction5 ? ALUMUX_SEXT5 : ALUMUX_SR2;
               aluop        = (opcode == op_and) ? alu_and : ((opcode == op_not) ? alu_not : alu_add);
               load_regfile = 1'b1;
               load_cc      = 1'b1;
            end
            S_SHF: begin
               alumux_sel   = ALUMUX_ZEXT4;
               aluop        = !instruction4 ? alu_sll : (instruction5 ? alu_sra : alu_srl);
               load_regfile = 1'b1;
               load_cc      = 1'b1;
            end
            S_LEA: begin
               regfilemux_sel = RFMUX_BRADD;
               load_regfile   = 1'b1;
               load_cc        = 1'b1;
            end
            S_BR_TAKEN: begin
               pcmux_sel = PCMUX_BRADD;
               load_pc   = 1'b1;
            end
            S_JMP: begin
               pcmux_sel = PCMUX_SR1;
               load_pc   = 1'b1;
            end
            S_STORE_R7: begin
               destmux_sel    = 1'b1;
               regfilemux_sel = RFMUX_PC;
               load_regfile   = 1'b1;
            end
            S_JSR_PC: begin
               pcmux_sel     = instruction11 ? PCMUX_BRADD : PCMUX_SR1;
               offsetmux_sel = instruction11;
               load_pc       = 1'b1;
            end
            S_CALC_ADDR: begin
               alumux_sel = (opcode == op_ldr || opcode == op_str) ? ALUMUX_ADJ6 : ALUMUX_SEXT6;
               load_mar   = 1'b1;
            end
            S_LD_WB: begin
               if (opcode == op_ldb)
                  regfilemux_sel = mem_bus.mem_address0 ? RFMUX_ZEXTHI : RFMUX_ZEXTLO;
               else
                  regfilemux_sel = RFMUX_MDR;
               load_regfile = 1'b1;
               load_cc      = 1'b1;
            end
            S_ST_MDR: begin
               storemux_sel = 1'b1;
               mdrmux_sel   = MDRMUX_ALU;
               aluop        = alu_pass;
               load_mdr     = 1'b1;
            end
            S_ST_WR: begin
               wr_req = 1'b1;
               if (opcode == op_stb)
                  byte_en = mem_bus.mem_address0 ? 2'b10 : 2'b01;
            end
            S_TRAP_MAR: begin
               marmux_sel = MARMUX_TRAPVEC;
               load_mar   = 1'b1;
            end
            S_TRAP_PC: begin
               pcmux_sel = PCMUX_MDR;
               load_pc   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign mem_bus.mem_read        = rd_req;
   assign mem_bus.mem_write       = wr_req;
   assign mem_bus.mem_byte_enable = byte_en;

   // Sticky memory-error flag: set by any watchdog timeout, only reset clears it.
   always_ff @(posedge clk) begin
      if (rst)
         error_q <= 1'b0;
      else if (timeout)
         error_q <= 1'b1;
   end

   assign mem_error = error_q && !rst;

`ifdef CONTROL_PERF_CNT_EN
   logic instr_done;

   assign instr_done = (next_state == S_FETCH1) && !timeout &&
                       (state != S_FETCH1) && (state != S_FETCH2) && (state != S_FETCH3);

   // Free-running cycle and retired-instruction counters, both wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_count <= '0;
         instr_count <= '0;
      end else begin
         cycle_count <= cycle_count + 32'd1;
         if (instr_done)
            instr_count <= instr_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_control.sv
// Directed testbench for the LC-3b control FSM, built with MEM_TIMEOUT=8.
// Inputs are driven and outputs sampled just after the falling clock edge.
module tb_control;
   import control_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] opcode;
   logic       instruction4, instruction5, instruction11, branch_enable;
   logic [1:0] pcmux_sel, marmux_sel;
   logic [2:0] alumux_sel, regfilemux_sel, aluop;
   logic       storemux_sel, mdrmux_sel, destmux_sel, offsetmux_sel;
   logic       load_pc, load_cc, load_ir, load_mar, load_mdr, load_regfile;
   logic       mem_error;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   control_if bus ();

   control #(.MEM_TIMEOUT(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .opcode         (opcode),
      .instruction4   (instruction4),
      .instruction5   (instruction5),
      .instruction11  (instruction11),
      .branch_enable  (branch_enable),
      .mem_bus        (bus),
      .pcmux_sel      (pcmux_sel),
      .marmux_sel     (marmux_sel),
      .alumux_sel     (alumux_sel),
      .regfilemux_sel (regfilemux_sel),
      .storemux_sel   (storemux_sel),
      .mdrmux_sel     (mdrmux_sel),
      .destmux_sel    (destmux_sel),
      .offsetmux_sel  (offsetmux_sel),
      .load_pc        (load_pc),
      .load_cc        (load_cc),
      .load_ir        (load_ir),
      .load_mar       (load_mar),
      .load_mdr       (load_mdr),
      .load_regfile   (load_regfile),
      .aluop          (aluop),
      .mem_error      (mem_error)
   );

   task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic apply_stimulus(input logic [3:0] op, input logic i4, input logic i5,
                                 input logic i11, input logic be, input logic addr0);
      opcode            = op;
      instruction4      = i4;
      instruction5      = i5;
      instruction11     = i11;
      branch_enable     = be;
      bus.mem_address0  = addr0;
   endtask

   task automatic next_cycle(input logic resp);
      @(negedge clk);
      bus.mem_resp = resp;
      #1;
   endtask

   // Starts in FETCH1 and finishes settled in DECODE, with immediate memory response.
   task automatic run_fetch(input string tag);
      check_output($sformatf("%s_f1_load_mar", tag), 32'(load_mar), 1);
      check_output($sformatf("%s_f1_marmux", tag), 32'(marmux_sel), 1);
      check_output($sformatf("%s_f1_load_pc", tag), 32'(load_pc), 1);
      next_cycle(1'b1);
      check_output($sformatf("%s_f2_mem_read", tag), 32'(bus.mem_read), 1);
      check_output($sformatf("%s_f2_load_mdr", tag), 32'(load_mdr), 1);
      next_cycle(1'b1);
      check_output($sformatf("%s_f3_load_ir", tag), 32'(load_ir), 1);
      next_cycle(1'b1);
      check_output($sformatf("%s_decode_loads", tag),
                   32'({load_pc, load_cc, load_ir, load_mar, load_mdr, load_regfile,
                        bus.mem_read, bus.mem_write}), 0);
   endtask

   initial begin
      rst = 1'b1;
      bus.mem_resp = 1'b0;
      apply_stimulus(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      check_output("rst_loads", 32'({load_pc, load_ir, load_mar, load_mdr, load_regfile}), 0);
      check_output("rst_mem_rw", 32'({bus.mem_read, bus.mem_write}), 0);
      check_output("rst_byte_en", 32'(bus.mem_byte_enable), 3);
      check_output("rst_mem_error", 32'(mem_error), 0);
      @(negedge clk);
      rst = 1'b0;
      bus.mem_resp = 1'b1;
      #1;

      // ADD R1,R2,#-1 (0x12BF): IR5=1, IR4=1, IR11=0
      apply_stimulus(4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      run_fetch("add");
      next_cycle(1'b1);
      check_output("add_load_regfile", 32'(load_regfile), 1);
      check_output("add_load_cc", 32'(load_cc), 1);
      check_output("add_alumux", 32'(alumux_sel), 1);
      check_output("add_aluop", 32'(aluop), 0);
      next_cycle(1'b1);
      check_output("add_back_f1", 32'({load_mar, load_regfile}), 2);

      // LDR with three wait cycles before mem_resp
      apply_stimulus(4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_fetch("ldr");
      next_cycle(1'b1);
      check_output("ldr_calc_alumux", 32'(alumux_sel), 2);
      check_output("ldr_calc_load_mar", 32'(load_mar), 1);
      for (int i = 0; i < 4; i++) begin
         next_cycle(i == 3);
         check_output($sformatf("ldr_rd%0d_mem_read", i), 32'(bus.mem_read), 1);
         check_output($sformatf("ldr_rd%0d_load_mdr", i), 32'(load_mdr), 1);
         check_output($sformatf("ldr_rd%0d_no_wb", i), 32'(load_regfile), 0);
      end
      next_cycle(1'b1);
      check_output("ldr_wb_load_regfile", 32'(load_regfile), 1);
      check_output("ldr_wb_rfmux", 32'(regfilemux_sel), 1);
      next_cycle(1'b1);
      check_output("ldr_single_wb", 32'({load_mar, load_regfile, bus.mem_read}), 4);

      // LDB from the high byte lane
      apply_stimulus(4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      run_fetch("ldb");
      next_cycle(1'b1);
      check_output("ldb_calc_alumux", 32'(alumux_sel), 4);
      next_cycle(1'b1);
      check_output("ldb_rd_mem_read", 32'(bus.mem_read), 1);
      next_cycle(1'b1);
      check_output("ldb_wb_rfmux", 32'(regfilemux_sel), 5);
      next_cycle(1'b1);

      // STB to an odd address, two wait cycles
      apply_stimulus(4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      run_fetch("stb");
      next_cycle(1'b1);
      check_output("stb_calc_alumux", 32'(alumux_sel), 4);
      next_cycle(1'b1);
      check_output("stb_mdr_storemux", 32'(storemux_sel), 1);
      check_output("stb_mdr_aluop", 32'(aluop), 3);
      check_output("stb_mdr_load", 32'({load_mdr, mdrmux_sel}), 2);
      for (int i = 0; i < 3; i++) begin
         next_cycle(i == 2);
         check_output($sformatf("stb_wr%0d_mem_write", i), 32'(bus.mem_write), 1);
         check_output($sformatf("stb_wr%0d_byte_en", i), 32'(bus.mem_byte_enable), 2);
      end
      next_cycle(1'b1);
      check_output("stb_done_mem_write", 32'(bus.mem_write), 0);
      check_output("stb_done_byte_en", 32'(bus.mem_byte_enable), 3);

      // BRz not taken, then taken
      apply_stimulus(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_fetch("brnt");
      next_cycle(1'b1);
      check_output("brnt_to_f1", 32'({load_mar, pcmux_sel}), 4);
      apply_stimulus(4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      run_fetch("brt");
      next_cycle(1'b1);
      check_output("brt_pcmux", 32'(pcmux_sel), 1);
      check_output("brt_loads", 32'({load_pc, load_mar}), 2);
      next_cycle(1'b1);

      // SHF arithmetic right (IR5=1, IR4=1)
      apply_stimulus(4'hD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      run_fetch("shf");
      next_cycle(1'b1);
      check_output("shf_aluop", 32'(aluop), 6);
      check_output("shf_alumux", 32'(alumux_sel), 3);
      next_cycle(1'b1);

      // JSR (IR11=1)
      apply_stimulus(4'h4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      run_fetch("jsr");
      next_cycle(1'b1);
      check_output("jsr_r7", 32'({destmux_sel, regfilemux_sel, load_regfile}), 5'b10111);
      next_cycle(1'b1);
      check_output("jsr_pc", 32'({pcmux_sel, offsetmux_sel, load_pc}), 4'b0111);
      next_cycle(1'b1);

      // TRAP
      apply_stimulus(4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_fetch("trap");
      next_cycle(1'b1);
      check_output("trap_r7", 32'({destmux_sel, load_regfile}), 3);
      next_cycle(1'b1);
      check_output("trap_mar", 32'({marmux_sel, load_mar}), 7);
      next_cycle(1'b1);
      check_output("trap_rd", 32'(bus.mem_read), 1);
      next_cycle(1'b1);
      check_output("trap_pc", 32'({pcmux_sel, load_pc}), 7);
      next_cycle(1'b1);

      // Undefined opcode (RTI) returns straight to fetch
      apply_stimulus(4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_fetch("undef");
      next_cycle(1'b1);
      check_output("undef_to_f1", 32'({load_mar, load_regfile, load_pc}), 5);

      // Reset during FETCH2
      apply_stimulus(4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      next_cycle(1'b0);
      check_output("rstmid_f2_mem_read", 32'(bus.mem_read), 1);
      rst = 1'b1;
      #1;
      check_output("rstmid_drop", 32'({bus.mem_read, load_mdr}), 0);
      @(negedge clk);
      rst = 1'b0;
      bus.mem_resp = 1'b1;
      #1;
      check_output("rstmid_f1", 32'({load_mar, load_ir, bus.mem_read}), 4);
      next_cycle(1'b1);
      next_cycle(1'b1);
      next_cycle(1'b1);
      next_cycle(1'b1);
      next_cycle(1'b1);
      check_output("rstmid_resume_f1", 32'(load_mar), 1);

      // Memory never responds: timeout after 8 wait cycles
      for (int i = 0; i < 8; i++) begin
         next_cycle(1'b0);
         check_output($sformatf("tmo_wait%0d", i), 32'({bus.mem_read, mem_error}), 2);
      end
      next_cycle(1'b0);
      check_output("tmo_error_set", 32'(mem_error), 1);
      check_output("tmo_back_f1", 32'({load_mar, bus.mem_read}), 2);
      next_cycle(1'b1);
      next_cycle(1'b1);
      next_cycle(1'b1);
      check_output("tmo_error_sticky", 32'(mem_error), 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check_output("tmo_error_cleared", 32'(mem_error), 0);
      rst = 1'b0;
      #1;
      check_output("tmo_error_after_rst", 32'(mem_error), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
